// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data access, with per-access timeout and sticky bus error.
// Optional MEM_ARB_RR_EN replaces fixed data priority with round-robin arbitration on contention.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_D, OWN_I} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [DATA_W-1:0] iload_nxt, dload_nxt, ramstore_nxt;
  logic [ADDR_W-1:0] ramaddr_nxt;
  logic              ihit_nxt, dhit_nxt, ramREN_nxt, ramWEN_nxt, bus_err_nxt;
  logic              d_req, grant_d, grant_i;
`ifdef MEM_ARB_RR_EN
  owner_t            last, last_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    cnt_inc      = cnt + CW'(1);
    iload_nxt    = iload;
    dload_nxt    = dload;
    ramstore_nxt = ramstore;
    ramaddr_nxt  = ramaddr;
    ramREN_nxt   = ramREN;
    ramWEN_nxt   = ramWEN;
    bus_err_nxt  = bus_err;
    ihit_nxt     = 1'b0;
    dhit_nxt     = 1'b0;
    d_req        = dREN | dWEN;
`ifdef MEM_ARB_RR_EN
    last_nxt     = last;
    // On contention the requester that did not own the bus last wins.
    grant_d      = (d_req && iREN) ? (last == OWN_I) : d_req;
`else
    grant_d      = d_req;
`endif
    grant_i      = iREN & ~grant_d;

    case (state)
      IDLE: begin
        if (grant_d) begin
          owner_nxt    = OWN_D;
          ramaddr_nxt  = daddr;
          ramWEN_nxt   = dWEN;
          ramREN_nxt   = ~dWEN;
          ramstore_nxt = dWEN ? dstore : '0;
          cnt_nxt      = '0;
          state_nxt    = WAIT;
`ifdef MEM_ARB_RR_EN
          last_nxt     = OWN_D;
`endif
        end else if (grant_i) begin
          owner_nxt    = OWN_I;
          ramaddr_nxt  = iaddr;
          ramREN_nxt   = 1'b1;
          ramWEN_nxt   = 1'b0;
          ramstore_nxt = '0;
          cnt_nxt      = '0;
          state_nxt    = WAIT;
`ifdef MEM_ARB_RR_EN
          last_nxt     = OWN_I;
`endif
        end
      end
      WAIT: begin
        if (ram_ready || cnt_inc == TMAX) begin
          if (owner == OWN_I) begin
            iload_nxt = ram_ready ? ramload : '0;
            ihit_nxt  = 1'b1;
          end else begin
            if (!ram_ready) dload_nxt = '0;
            else if (!ramWEN) dload_nxt = ramload;
            dhit_nxt = 1'b1;
          end
          if (!ram_ready) bus_err_nxt = 1'b1;
          ramREN_nxt = 1'b0;
          ramWEN_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = RESP;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= OWN_D;
      cnt      <= '0;
      iload    <= '0;
      dload    <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      bus_err  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last     <= OWN_I;
`endif
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      cnt      <= cnt_nxt;
      iload    <= iload_nxt;
      dload    <= dload_nxt;
      ihit     <= ihit_nxt;
      dhit     <= dhit_nxt;
      ramREN   <= ramREN_nxt;
      ramWEN   <= ramWEN_nxt;
      ramaddr  <= ramaddr_nxt;
      ramstore <= ramstore_nxt;
      bus_err  <= bus_err_nxt;
`ifdef MEM_ARB_RR_EN
      last     <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single accesses, scoreboard of expected hits,
// plus hand-written timeout, reset-abort and contention sequences.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, bus_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          use_i;
    bit          wr;
    bit          both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } vec_t;

  typedef struct {
    bit          is_i;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_dload = '0;
  logic        exp_err = 1'b0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_hit();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got hit with no expected entry");
      return;
    end
    e = sb.pop_front();
    check("ihit", {31'b0, ihit}, {31'b0, e.is_i});
    check("dhit", {31'b0, dhit}, {31'b0, !e.is_i});
    check("load_data", e.is_i ? iload : dload, e.data);
  endtask

  task automatic do_reset();
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    tick();
    tick();
    RST = 1'b0;
    model_dload = '0;
    exp_err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'b0, ihit, dhit, ramREN, ramWEN, bus_err, 1'b0}, 32'h0);
    check({tag, "_ramaddr"}, ramaddr, 32'h0);
    check({tag, "_ramstore"}, ramstore, 32'h0);
    check({tag, "_iload"}, iload, 32'h0);
    check({tag, "_dload"}, dload, 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.is_i = v.use_i;
    e.data = v.use_i ? v.rdata : (v.wr ? model_dload : v.rdata);
    if (!v.use_i) model_dload = e.data;
    sb.push_back(e);
    if (v.use_i) begin
      iREN = 1; iaddr = v.addr;
    end else begin
      dWEN = v.wr; dREN = !v.wr || v.both; daddr = v.addr; dstore = v.wdata;
    end
    tick();
    check("grant_ramREN", {31'b0, ramREN}, {31'b0, !v.wr});
    check("grant_ramWEN", {31'b0, ramWEN}, {31'b0, v.wr});
    check("grant_ramaddr", ramaddr, v.addr);
    if (v.use_i || v.wr) check("grant_ramstore", ramstore, v.use_i ? 32'h0 : v.wdata);
    iaddr = ~v.addr; daddr = ~v.addr; dstore = ~v.wdata;
    for (int k = 1; k <= v.delay; k++) begin
      if (k > 1) begin
        check("wait_ramaddr_held", ramaddr, v.addr);
        check("wait_enable_held", {31'b0, ramREN | ramWEN}, 32'h1);
      end
      check("wait_no_hit", {31'b0, ihit | dhit}, 32'h0);
      ram_ready = (k == v.delay);
      ramload = (k == v.delay) ? v.rdata : ~v.rdata;
      tick();
    end
    ram_ready = 0;
    checkOutput();
    iREN = 0; dREN = 0; dWEN = 0;
    tick();
    check("idle_no_hit", {31'b0, ihit | dhit}, 32'h0);
  endtask

  task automatic checkOutput();
    check("resp_enables_off", {31'b0, ramREN | ramWEN}, 32'h0);
    check("resp_bus_err", {31'b0, bus_err}, {31'b0, exp_err});
    check_hit();
  endtask

  initial begin
    vec_t v;
    bit   order_i[4];
    int   n_cont;
    int   budget;

    vecs[0] = '{use_i: 1, wr: 0, both: 0, addr: 32'h40,  wdata: 32'h0,        rdata: 32'hDEADBEEF, delay: 1};
    vecs[1] = '{use_i: 0, wr: 1, both: 0, addr: 32'h100, wdata: 32'h12345678, rdata: 32'h0,        delay: 2};
    vecs[2] = '{use_i: 0, wr: 0, both: 0, addr: 32'h200, wdata: 32'h0,        rdata: 32'hCAFEF00D, delay: 3};
    vecs[3] = '{use_i: 1, wr: 0, both: 0, addr: 32'h44,  wdata: 32'h0,        rdata: 32'h13579BDF, delay: 2};
    vecs[4] = '{use_i: 0, wr: 1, both: 0, addr: 32'h104, wdata: 32'hA5A5A5A5, rdata: 32'h0,        delay: 1};
    vecs[5] = '{use_i: 0, wr: 1, both: 1, addr: 32'h108, wdata: 32'h5A5A0001, rdata: 32'h0,        delay: 3};

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Timeout: RAM never answers, access aborts after TIMEOUT wait cycles.
    dREN = 1; daddr = 32'h300;
    tick();
    for (int k = 1; k < 4; k++) begin
      check("to_waiting_enable", {31'b0, ramREN}, 32'h1);
      check("to_no_hit_yet", {31'b0, dhit | ihit}, 32'h0);
      check("to_no_err_yet", {31'b0, bus_err}, 32'h0);
      tick();
    end
    check("to_still_waiting", {31'b0, ramREN}, 32'h1);
    tick();
    exp_err = 1'b1;
    model_dload = '0;
    sb.push_back('{is_i: 0, data: 32'h0});
    checkOutput();
    dREN = 0;
    tick();

    v = '{use_i: 0, wr: 0, both: 0, addr: 32'h304, wdata: 32'h0, rdata: 32'h0BADC0DE, delay: 2};
    applyStimulus(v);
    v = '{use_i: 1, wr: 0, both: 0, addr: 32'h48, wdata: 32'h0, rdata: 32'h77778888, delay: 1};
    applyStimulus(v);
    check("err_sticky_idle", {31'b0, bus_err}, 32'h1);

    // Reset in the first WAIT cycle aborts the access with no hit.
    iREN = 1; iaddr = 32'h80;
    tick();
    check("rst_wait_enable", {31'b0, ramREN}, 32'h1);
    RST = 1;
    tick();
    check_all_zero("rst_mid");
    RST = 0; iREN = 0; exp_err = 0; model_dload = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_no_hit", {31'b0, ihit | dhit}, 32'h0);
    end

    // Contention with both requests present in IDLE.
`ifdef MEM_ARB_RR_EN
    n_cont = 4;
    order_i = '{0, 1, 0, 1};
`else
    n_cont = 2;
    order_i = '{0, 1, 0, 1};
`endif
    iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h600;
    for (int k = 0; k < n_cont; k++) begin
      tick();
      check("cont_grant_addr", ramaddr, order_i[k] ? 32'h500 : 32'h600);
      ram_ready = 1;
      ramload = order_i[k] ? (32'h11110000 + k) : (32'h22220000 + k);
      if (!order_i[k]) model_dload = ramload;
      sb.push_back('{is_i: order_i[k], data: ramload});
      budget = 0;
      do begin
        tick();
        ram_ready = 0;
        budget++;
      end while (!(ihit || dhit) && budget < 10);
      check("cont_hit_seen", {31'b0, ihit | dhit}, 32'h1);
      check("cont_no_overlap", {31'b0, ihit & dhit}, 32'h0);
      check_hit();
`ifndef MEM_ARB_RR_EN
      if (!order_i[k]) dREN = 0;
`endif
      if (k == n_cont - 1) begin
        iREN = 0; dREN = 0;
      end
      tick();
    end

    v = '{use_i: 1, wr: 0, both: 0, addr: 32'h84, wdata: 32'h0, rdata: 32'hFEEDFACE, delay: 1};
    applyStimulus(v);
    check("final_no_err", {31'b0, bus_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
